roc_decoder: RTL and testbench

- Receiving end of the rank-order-coded (ROC) spike stream that the ROC encoder produces.
- Accepts one pixel index per event over a 4-phase asynchronous AER REQ/ACK link.
- Assigns each newly seen index an intensity from its arrival rank: first spike gives the brightest value.
- Rebuilds the image and raises a ready flag after IMAGE_SIZE distinct indices. Used for loopback checking of the encoder and for reconstructing output spike trains.

---
 rtl/roc_decoder.sv | 192 +++++++++++++++++++
 tb/tb_roc_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/roc_decoder.sv
// Rank-order-coded spike decoder: receives pixel indices over a 4-phase AER
// link and rebuilds an image whose intensity falls with arrival rank.
module roc_decoder #(
  parameter int unsigned IMAGE_SIZE      = 7,
  parameter int unsigned PIXEL_MAX_VALUE = 255,
  parameter int unsigned PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int unsigned RANK_BITS       = $clog2(IMAGE_SIZE + 1)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             START,
  input  logic [9:0]                       AERIN_ADDR,
  input  logic                             AERIN_REQ,
  output logic                             AERIN_ACK,
  output logic [IMAGE_SIZE*PIXEL_BITS-1:0] IMAGE_OUT,
  output logic [RANK_BITS-1:0]             RANK,
  output logic                             DECODER_RDY,
  output logic                             DUP_ERR,
  output logic                             RANGE_ERR
);

  localparam int unsigned ADDR_BITS = 10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REQ = 3'd1,
    S_CAPTURE  = 3'd2,
    S_WAIT_LOW = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                 state_q, state_nxt;

  logic                   req_m, req_s, req_d;
  logic                   req_event;

  logic [ADDR_BITS-1:0]   addr_q, addr_nxt;
  logic                   ack_q, ack_nxt;
  logic [RANK_BITS-1:0]   rank_q, rank_nxt;
  logic                   rdy_q, rdy_nxt;
  logic                   dup_q, dup_nxt;
  logic                   rng_q, rng_nxt;
  logic [IMAGE_SIZE-1:0]  bitmap_q, bitmap_nxt;
  logic [PIXEL_BITS-1:0]  pix_q   [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0]  pix_nxt [IMAGE_SIZE];

  logic [IMAGE_SIZE-1:0]  addr_hot;
  logic                   addr_out_of_range;
  logic                   addr_seen;
  logic [PIXEL_BITS-1:0]  pix_val;
  logic                   image_full;

  // Two-flop REQ synchronizer plus one delay stage for rising-edge detection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
      req_d <= 1'b0;
    end else begin
      req_m <= AERIN_REQ;
      req_s <= req_m;
      req_d <= req_s;
    end
  end

  assign req_event = req_s & ~req_d;

  // One-hot decode of the captured address and classification helpers
  always_comb begin
    for (int i = 0; i < int'(IMAGE_SIZE); i++) begin
      addr_hot[i] = (addr_q == ADDR_BITS'(i));
    end
    addr_out_of_range = (addr_q >= ADDR_BITS'(IMAGE_SIZE));
    addr_seen         = |(bitmap_q & addr_hot);
    image_full        = (rank_q == RANK_BITS'(IMAGE_SIZE));
    if (32'(rank_q) < PIXEL_MAX_VALUE) begin
      pix_val = PIXEL_BITS'(PIXEL_MAX_VALUE - 32'(rank_q));
    end else begin
      pix_val = '0;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; START overrides everything, including a same-cycle event
  always_comb begin
    state_nxt = state_q;
    if (START) begin
      state_nxt = S_WAIT_REQ;
    end else begin
      case (state_q)
        S_IDLE:     state_nxt = S_IDLE;
        S_WAIT_REQ: if (req_event) state_nxt = S_CAPTURE;
        S_CAPTURE:  state_nxt = S_WAIT_LOW;
        S_WAIT_LOW: if (!req_s) state_nxt = image_full ? S_DONE : S_WAIT_REQ;
        S_DONE:     state_nxt = S_DONE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and the image store
  always_comb begin
    addr_nxt   = addr_q;
    ack_nxt    = ack_q;
    rank_nxt   = rank_q;
    rdy_nxt    = rdy_q;
    dup_nxt    = dup_q;
    rng_nxt    = rng_q;
    bitmap_nxt = bitmap_q;
    pix_nxt    = pix_q;
    if (START) begin
      ack_nxt    = 1'b0;
      rank_nxt   = '0;
      rdy_nxt    = 1'b0;
      dup_nxt    = 1'b0;
      rng_nxt    = 1'b0;
      bitmap_nxt = '0;
      for (int i = 0; i < int'(IMAGE_SIZE); i++) pix_nxt[i] = '0;
    end else begin
      case (state_q)
        S_WAIT_REQ: begin
          if (req_event) addr_nxt = AERIN_ADDR;
        end
        S_CAPTURE: begin
          ack_nxt = 1'b1;
          if (addr_out_of_range) begin
            rng_nxt = 1'b1;
          end else if (addr_seen) begin
            dup_nxt = 1'b1;
          end else begin
            for (int i = 0; i < int'(IMAGE_SIZE); i++) begin
              if (addr_hot[i]) pix_nxt[i] = pix_val;
            end
            bitmap_nxt = bitmap_q | addr_hot;
            rank_nxt   = rank_q + RANK_BITS'(1);
          end
        end
        S_WAIT_LOW: begin
          if (!req_s) begin
            ack_nxt = 1'b0;
            if (image_full) rdy_nxt = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output and image registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q   <= '0;
      ack_q    <= 1'b0;
      rank_q   <= '0;
      rdy_q    <= 1'b0;
      dup_q    <= 1'b0;
      rng_q    <= 1'b0;
      bitmap_q <= '0;
      for (int i = 0; i < int'(IMAGE_SIZE); i++) pix_q[i] <= '0;
    end else begin
      addr_q   <= addr_nxt;
      ack_q    <= ack_nxt;
      rank_q   <= rank_nxt;
      rdy_q    <= rdy_nxt;
      dup_q    <= dup_nxt;
      rng_q    <= rng_nxt;
      bitmap_q <= bitmap_nxt;
      pix_q    <= pix_nxt;
    end
  end

  // Flatten the pixel store onto the image bus
  for (genvar g = 0; g < int'(IMAGE_SIZE); g++) begin : g_image
    assign IMAGE_OUT[g*PIXEL_BITS +: PIXEL_BITS] = pix_q[g];
  end

  assign AERIN_ACK   = ack_q;
  assign RANK        = rank_q;
  assign DECODER_RDY = rdy_q;
  assign DUP_ERR     = dup_q;
  assign RANGE_ERR   = rng_q;

endmodule

// File: tb/tb_roc_decoder.sv
// Randomized bench for roc_decoder against an arrival-order reference model.
module tb_roc_decoder;

  localparam int N    = 7;
  localparam int PMAX = 255;
  localparam int PB   = 8;
  localparam int RB   = 3;

  logic            CLK;
  logic            RST;
  logic            START;
  logic [9:0]      AERIN_ADDR;
  logic            AERIN_REQ;
  logic            AERIN_ACK;
  logic [N*PB-1:0] IMAGE_OUT;
  logic [RB-1:0]   RANK;
  logic            DECODER_RDY;
  logic            DUP_ERR;
  logic            RANGE_ERR;

  roc_decoder dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .AERIN_ADDR  (AERIN_ADDR),
    .AERIN_REQ   (AERIN_REQ),
    .AERIN_ACK   (AERIN_ACK),
    .IMAGE_OUT   (IMAGE_OUT),
    .RANK        (RANK),
    .DECODER_RDY (DECODER_RDY),
    .DUP_ERR     (DUP_ERR),
    .RANGE_ERR   (RANGE_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: the list of distinct indices in arrival order
  int order[$];
  bit m_dup, m_rng, m_active, m_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*PB-1:0] model_image();
    logic [N*PB-1:0] img;
    img = '0;
    foreach (order[k]) img[order[k]*PB +: PB] = (k < PMAX) ? PB'(PMAX - k) : '0;
    return img;
  endfunction

  function automatic bit model_seen(input int a);
    foreach (order[k]) if (order[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset(input bit active);
    order.delete();
    m_dup = 0; m_rng = 0; m_done = 0; m_active = active;
  endtask

  task automatic model_event(input int a);
    if (a >= N) m_rng = 1;
    else if (model_seen(a)) m_dup = 1;
    else order.push_back(a);
    if (order.size() == N) begin
      m_done = 1; m_active = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".image"}, 64'(IMAGE_OUT), 64'(model_image()));
    chk({tag, ".rank"},  64'(RANK), 64'(order.size()));
    chk({tag, ".rdy"},   64'(DECODER_RDY), 64'(m_done));
    chk({tag, ".dup"},   64'(DUP_ERR), 64'(m_dup));
    chk({tag, ".rng"},   64'(RANGE_ERR), 64'(m_rng));
    chk({tag, ".ack"},   64'(AERIN_ACK), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    model_reset(1'b1);
    check_all("start");
  endtask

  // One full 4-phase handshake; events outside an active decode must not be acknowledged
  task automatic send(input int a);
    int  n;
    bit  seen;
    bit  exp_ack;
    exp_ack = m_active;
    @(negedge CLK);
    AERIN_ADDR = 10'(a);
    AERIN_REQ  = 1'b1;
    if (exp_ack) begin
      n = 0; seen = 0;
      while (!seen && n < 20) begin
        @(posedge CLK); n++;
        @(negedge CLK); if (AERIN_ACK) seen = 1;
      end
      chk("ack_rise_lat", 64'(n), 64'd4);
      model_event(a);
      AERIN_REQ = 1'b0;
      n = 0; seen = 0;
      while (!seen && n < 20) begin
        @(posedge CLK); n++;
        @(negedge CLK); if (!AERIN_ACK) seen = 1;
      end
      chk("ack_fall_lat", 64'(n), 64'd3);
    end else begin
      seen = 0;
      repeat (12) begin
        @(negedge CLK); if (AERIN_ACK) seen = 1;
      end
      chk("no_ack", 64'(seen), 64'd0);
      AERIN_REQ = 1'b0;
      repeat (3) @(negedge CLK);
    end
    check_all("event");
    repeat ($urandom_range(0, 2)) @(negedge CLK);
  endtask

  initial begin
    int seq[7];
    int n;
    bit seen;
    seq = '{3, 0, 6, 1, 5, 2, 4};
    RST = 1'b0; START = 1'b0; AERIN_ADDR = '0; AERIN_REQ = 1'b0;
    model_reset(1'b0);
    repeat (3) @(negedge CLK);
    check_all("reset");
    RST = 1'b1;
    @(negedge CLK);

    // IDLE ignores requests until START
    send(2);

    // Nominal decode followed by a request in DONE
    pulse_start();
    foreach (seq[i]) send(seq[i]);
    chk("nominal.pix4", 64'(IMAGE_OUT[4*PB +: PB]), 64'd249);
    send(2);

    // Duplicate index
    pulse_start();
    send(4); send(4); send(1);

    // Out-of-range index
    pulse_start();
    send(9);

    // Restart mid-stream
    pulse_start();
    repeat (3) send($urandom_range(0, N - 1));
    pulse_start();
    send(5);

    // Randomized decodes with occasional duplicates and out-of-range indices
    for (int r = 0; r < 6; r++) begin
      pulse_start();
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 3) == 0) send($urandom_range(0, 9));
        else send($urandom_range(0, N - 1));
      end
    end

    // Asynchronous reset while ACK is held high
    pulse_start();
    send(1);
    @(negedge CLK);
    AERIN_ADDR = 10'd2;
    AERIN_REQ  = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge CLK); n++;
      @(negedge CLK); if (AERIN_ACK) seen = 1;
    end
    chk("arst.ack_before", 64'(AERIN_ACK), 64'd1);
    #2 RST = 1'b0;
    #1;
    model_reset(1'b0);
    check_all("arst");
    #1 RST = 1'b1;
    repeat (4) @(negedge CLK);
    chk("arst.idle_ack", 64'(AERIN_ACK), 64'd0);
    AERIN_REQ = 1'b0;
    repeat (4) @(negedge CLK);
    send(3);
    pulse_start();
    send(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
